// File: rtl/sram_pri_data_ctrl.sv
// Request-side controller for the private data SRAM: zero-fills the array after reset,
// drives the active-low SRAM strobes and returns read data through a credited response FIFO.
module sram_pri_data_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 128,
  parameter int RSP_DEPTH  = 3,
  parameter bit INIT_EN    = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic                  init_done_o,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [15:0]           req_be_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  mem_cen_o,
  output logic                  mem_wen_o,
  output logic [15:0]           mem_ben_o,
  output logic [ADDR_WIDTH-1:0] mem_a_o,
  output logic [DATA_WIDTH-1:0] mem_d_o,
  input  logic [DATA_WIDTH-1:0] mem_q_i
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  typedef enum logic [1:0] {
    S_RST,
    S_INIT,
    S_RUN
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q;
  logic                  inflight_p1;
  logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;

  logic                  credit_ok;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic                  fifo_empty;
  logic                  fifo_full;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Every read in the SRAM pipe already owns a FIFO slot, so overflow cannot happen.
  assign credit_ok  = ({1'b0, count_q} + {{CNT_W{1'b0}}, inflight_p1}) < (CNT_W + 1)'(RSP_DEPTH);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(RSP_DEPTH));
  assign accept     = req_valid_i & req_ready_o;
  assign push       = inflight_p1;
  assign pop        = rsp_valid_o & rsp_ready_i;

  always_comb begin
    state_d     = state_q;
    mem_cen_o   = 1'b1;
    mem_wen_o   = 1'b1;
    mem_ben_o   = '1;
    mem_a_o     = '0;
    mem_d_o     = '0;
    req_ready_o = 1'b0;
    init_done_o = 1'b0;
    case (state_q)
      S_RST: begin
        state_d = INIT_EN ? S_INIT : S_RUN;
      end
      S_INIT: begin
        mem_cen_o = 1'b0;
        mem_wen_o = 1'b0;
        mem_ben_o = '0;
        mem_a_o   = init_cnt_q;
        if (init_cnt_q == '1) state_d = S_RUN;
      end
      S_RUN: begin
        init_done_o = 1'b1;
        req_ready_o = credit_ok;
        mem_cen_o   = ~(req_valid_i & credit_ok);
        mem_wen_o   = ~req_we_i;
        mem_ben_o   = ~req_be_i;
        mem_a_o     = req_addr_i;
        mem_d_o     = req_wdata_i;
      end
      default: state_d = S_RST;
    endcase
  end

  // Stage p0 -> p1: control state, read-in-flight flag and FIFO bookkeeping
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_RST;
      init_cnt_q  <= '0;
      inflight_p1 <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      inflight_p1 <= accept & ~req_we_i;
      if (state_q == S_INIT) init_cnt_q <= init_cnt_q + 1'b1;
      if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Stage p1 -> p2: SRAM read data lands in the response FIFO
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= mem_q_i;
  end

  assign rsp_valid_o = ~fifo_empty;
  assign rsp_rdata_o = fifo_empty ? '0 : fifo_mem[rd_ptr_q];

`ifndef SYNTHESIS
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && fifo_full));
`endif

endmodule

// File: tb/tb_sram_pri_data_ctrl.sv
// Bench for sram_pri_data_ctrl: behavioural SRAM plus a transaction-level reference memory
// and an ordered queue of expected read responses.
module tb_sram_pri_data_ctrl;
  localparam int AW = 4;
  localparam int DW = 128;
  localparam int NW = 16;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          init_done_o;
  logic          req_valid_i;
  logic          req_ready_o;
  logic          req_we_i;
  logic [AW-1:0] req_addr_i;
  logic [DW-1:0] req_wdata_i;
  logic [15:0]   req_be_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [DW-1:0] rsp_rdata_o;
  logic          mem_cen_o;
  logic          mem_wen_o;
  logic [15:0]   mem_ben_o;
  logic [AW-1:0] mem_a_o;
  logic [DW-1:0] mem_d_o;
  logic [DW-1:0] mem_q_i;

  always #5 clk = ~clk;

  sram_pri_data_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(3), .INIT_EN(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .init_done_o(init_done_o),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .mem_cen_o(mem_cen_o), .mem_wen_o(mem_wen_o), .mem_ben_o(mem_ben_o),
    .mem_a_o(mem_a_o), .mem_d_o(mem_d_o), .mem_q_i(mem_q_i)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_rsp = 0;
  bit chk_lat = 1'b0;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic [DW-1:0] sram    [NW];
  logic [DW-1:0] ref_mem [NW];
  exp_t          exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port SRAM; q is garbage on cycles that follow no read.
  always @(posedge clk) begin
    if (!mem_cen_o && !mem_wen_o) begin
      for (int b = 0; b < 16; b++)
        if (!mem_ben_o[b]) sram[mem_a_o][8*b +: 8] <= mem_d_o[8*b +: 8];
      mem_q_i <= {$urandom, $urandom, $urandom, $urandom};
    end else if (!mem_cen_o) begin
      mem_q_i <= sram[mem_a_o];
    end else begin
      mem_q_i <= {$urandom, $urandom, $urandom, $urandom};
    end
  end

  // Transaction monitor: accepted requests update the reference; responses are matched in order.
  always @(negedge clk) begin
    #2;
    if (rst_ni && init_done_o) begin
      if (rsp_valid_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: rsp_valid_o=1 with no read outstanding at cycle %0d", cyc);
        end else begin
          if (rsp_rdata_o !== exp_q[0].data) begin
            errors++;
            $display("FAIL rsp_data: got %h required %h", rsp_rdata_o, exp_q[0].data);
          end
          if (rsp_ready_i) begin
            if (chk_lat) begin
              checks++;
              if (cyc !== exp_q[0].cyc + 2) begin
                errors++;
                $display("FAIL rsp_latency: response at cycle %0d required %0d", cyc, exp_q[0].cyc + 2);
              end
            end
            void'(exp_q.pop_front());
            n_rsp++;
          end
        end
      end
      if (req_valid_i && req_ready_o) begin
        checks++;
        if ({mem_cen_o, mem_wen_o, mem_ben_o, mem_a_o, mem_d_o} !==
            {1'b0, ~req_we_i, ~req_be_i, req_addr_i, req_wdata_i}) begin
          errors++;
          $display("FAIL mem_strobe: cen=%b wen=%b ben=%h a=%h for we=%b be=%h addr=%h",
                   mem_cen_o, mem_wen_o, mem_ben_o, mem_a_o, req_we_i, req_be_i, req_addr_i);
        end
        if (req_we_i) begin
          for (int b = 0; b < 16; b++)
            if (req_be_i[b]) ref_mem[req_addr_i][8*b +: 8] = req_wdata_i[8*b +: 8];
        end else begin
          exp_q.push_back('{data: ref_mem[req_addr_i], cyc: cyc});
        end
      end
    end
  end

  task automatic send(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                      input logic [15:0] be, output int waited);
    @(negedge clk);
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_wdata_i = data;
    req_be_i    = be;
    #1;
    waited = 0;
    while (!req_ready_o && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (waited >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: req_ready_o=%b after %0d cycles, required 1", req_ready_o, waited);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid_i = 1'b0;
    req_we_i    = $urandom_range(0, 1);
    req_addr_i  = AW'($urandom);
    req_wdata_i = {$urandom, $urandom, $urandom, $urandom};
    req_be_i    = 16'($urandom);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      #3;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic run_init(input int abort_at);
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    checks++;
    if ({mem_cen_o, init_done_o, req_ready_o} !== 3'b100) begin
      errors++;
      $display("FAIL s_rst_cycle: cen/done/ready=%b required 100", {mem_cen_o, init_done_o, req_ready_o});
    end
    for (int i = 0; i < NW; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({mem_cen_o, mem_wen_o, mem_ben_o, mem_a_o, mem_d_o, req_ready_o, init_done_o} !==
          {1'b0, 1'b0, 16'h0000, AW'(i), {DW{1'b0}}, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL init_sweep_%0d: cen=%b wen=%b ben=%h a=%0d ready=%b done=%b required a=%0d with strobes low",
                 i, mem_cen_o, mem_wen_o, mem_ben_o, mem_a_o, req_ready_o, init_done_o, i);
      end
      if (i == abort_at) begin
        rst_ni = 1'b0;
        exp_q.delete();
        return;
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if ({init_done_o, req_ready_o, mem_cen_o} !== 3'b111) begin
      errors++;
      $display("FAIL init_done: done/ready/cen=%b required 111", {init_done_o, req_ready_o, mem_cen_o});
    end
    for (int a = 0; a < NW; a++) ref_mem[a] = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_ni      = 1'b0;
    rsp_ready_i = 1'b1;
    req_valid_i = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({mem_cen_o, mem_wen_o, mem_ben_o, mem_a_o, mem_d_o, req_ready_o, rsp_valid_o, init_done_o, rsp_rdata_o} !==
        {1'b1, 1'b1, 16'hFFFF, {AW{1'b0}}, {DW{1'b0}}, 1'b0, 1'b0, 1'b0, {DW{1'b0}}}) begin
      errors++;
      $display("FAIL reset_outputs: cen=%b wen=%b ben=%h a=%h d=%h ready=%b rvalid=%b done=%b rdata=%h",
               mem_cen_o, mem_wen_o, mem_ben_o, mem_a_o, mem_d_o, req_ready_o, rsp_valid_o, init_done_o, rsp_rdata_o);
    end
  endtask

  task automatic test_init_sweep();
    int w;
    run_init(-1);
    chk_lat = 1'b1;
    send(1'b0, 4'd9, '0, '0, w);
    idle();
    wait_drain();
  endtask

  task automatic test_write_read();
    int w;
    int t0;
    logic [DW-1:0] d = 128'h0123456789ABCDEF0123456789ABCDEF;
    chk_lat = 1'b1;
    send(1'b1, 4'd3, d, 16'hFFFF, w);
    checks++;
    if ({mem_cen_o, mem_wen_o, mem_ben_o} !== {1'b0, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL wr_strobe: cen=%b wen=%b ben=%h required 0 0 0000", mem_cen_o, mem_wen_o, mem_ben_o);
    end
    send(1'b0, 4'd3, '0, '0, w);
    t0 = cyc;
    idle();
    #1;
    checks++;
    if (rsp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rd_lat_n1: rsp_valid_o=%b at N+1 required 0", rsp_valid_o);
    end
    @(negedge clk);
    #1;
    checks++;
    if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== d || cyc !== t0 + 2) begin
      errors++;
      $display("FAIL rd_lat_n2: rsp_valid_o=%b rdata=%h required 1 %h", rsp_valid_o, rsp_rdata_o, d);
    end
    wait_drain();
  endtask

  task automatic test_throughput();
    int w;
    int base = n_rsp;
    chk_lat = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(1'b0, AW'(i), '0, '0, w);
      checks++;
      if (w != 0) begin
        errors++;
        $display("FAIL tput_accept_%0d: waited %0d cycles, required 0", i, w);
      end
    end
    idle();
    wait_drain();
    checks++;
    if (n_rsp - base != 8) begin
      errors++;
      $display("FAIL tput_count: %0d responses, required 8", n_rsp - base);
    end
  endtask

  task automatic test_backpressure();
    int w;
    int base = n_rsp;
    chk_lat = 1'b0;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(1'b0, AW'(i + 10), '0, '0, w);
      checks++;
      if (w != 0) begin
        errors++;
        $display("FAIL bp_accept_%0d: waited %0d cycles, required 0", i, w);
      end
    end
    @(negedge clk);
    req_addr_i = 4'd13;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (req_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall_%0d: req_ready_o=%b required 0", k, req_ready_o);
      end
      @(negedge clk);
    end
    rsp_ready_i = 1'b1;
    send(1'b0, 4'd13, '0, '0, w);
    send(1'b0, 4'd14, '0, '0, w);
    idle();
    wait_drain();
    checks++;
    if (n_rsp - base != 5) begin
      errors++;
      $display("FAIL bp_count: %0d responses, required 5", n_rsp - base);
    end
  endtask

  task automatic test_byte_enables();
    int w;
    chk_lat = 1'b1;
    send(1'b1, 4'd5, {$urandom, $urandom, $urandom, $urandom}, 16'h0000, w);
    checks++;
    if (mem_ben_o !== 16'hFFFF || mem_cen_o !== 1'b0) begin
      errors++;
      $display("FAIL be_none: ben=%h cen=%b required FFFF 0", mem_ben_o, mem_cen_o);
    end
    send(1'b0, 4'd5, '0, '0, w);
    send(1'b1, 4'd5, {$urandom, $urandom, $urandom, $urandom}, 16'h0001, w);
    checks++;
    if (mem_ben_o !== 16'hFFFE) begin
      errors++;
      $display("FAIL be_byte0: ben=%h required FFFE", mem_ben_o);
    end
    send(1'b0, 4'd5, '0, '0, w);
    idle();
    wait_drain();
  endtask

  task automatic test_random();
    chk_lat = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rsp_ready_i = ($urandom_range(0, 3) != 0);
      req_valid_i = ($urandom_range(0, 2) != 0);
      req_we_i    = $urandom_range(0, 1);
      req_addr_i  = AW'($urandom);
      req_wdata_i = {$urandom, $urandom, $urandom, $urandom};
      req_be_i    = 16'($urandom);
    end
    idle();
    rsp_ready_i = 1'b1;
    wait_drain();
  endtask

  task automatic test_reset_mid_init();
    int w;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    send(1'b0, 4'd1, '0, '0, w);
    send(1'b0, 4'd2, '0, '0, w);
    idle();
    @(negedge clk);
    rst_ni = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if ({rsp_valid_o, rsp_rdata_o, req_ready_o, init_done_o} !== {1'b0, {DW{1'b0}}, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_flush: rvalid=%b rdata=%h ready=%b done=%b required all 0",
               rsp_valid_o, rsp_rdata_o, req_ready_o, init_done_o);
    end
    rsp_ready_i = 1'b1;
    run_init(7);
    #1;
    checks++;
    if ({mem_cen_o, mem_wen_o, mem_ben_o, mem_a_o, mem_d_o, req_ready_o, rsp_valid_o, init_done_o} !==
        {1'b1, 1'b1, 16'hFFFF, {AW{1'b0}}, {DW{1'b0}}, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_init: cen=%b wen=%b ben=%h a=%h ready=%b rvalid=%b done=%b",
               mem_cen_o, mem_wen_o, mem_ben_o, mem_a_o, req_ready_o, rsp_valid_o, init_done_o);
    end
    repeat (2) @(negedge clk);
    run_init(-1);
    chk_lat = 1'b1;
    send(1'b0, 4'd12, '0, '0, w);
    idle();
    wait_drain();
  endtask

  initial begin
    rst_ni      = 1'b0;
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    req_be_i    = '0;
    rsp_ready_i = 1'b1;
    test_reset();
    test_init_sweep();
    test_write_read();
    test_throughput();
    test_backpressure();
    test_byte_enables();
    test_random();
    test_reset_mid_init();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_pri_data_ctrl.md
Name: sram_pri_data_ctrl

Overview:
Request-side controller placed directly upstream of the private data SRAM wrapper.
- After reset it zero-fills the whole array.
- It then converts a valid/ready request channel into the wrapper's active-low CEN/WEN/BEN strobes.
- Read data returned by the memory is captured into a small response FIFO with valid/ready backpressure.
- Credit-based flow control guarantees that every read issued to the SRAM has a free response slot.

Parameters:
- ADDR_WIDTH, 4: SRAM address width; the array holds 2**ADDR_WIDTH words.
- DATA_WIDTH, 128: SRAM word width.
- RSP_DEPTH, 3: response FIFO depth, minimum 2. The value 3 gives full read throughput with no combinational pop-to-ready path.
- INIT_EN, 1: 1 = zero-fill the array after reset; 0 = go straight to RUN.

Ports:
- clk_i, in, 1: clock.
- rst_ni, in, 1: asynchronous active-low reset.
- init_done_o, out, 1: high once the block is in RUN.
- req_valid_i, in, 1: request valid.
- req_ready_o, out, 1: request ready.
- req_we_i, in, 1: 1 = write, 0 = read.
- req_addr_i, in, ADDR_WIDTH: word address.
- req_wdata_i, in, DATA_WIDTH: write data.
- req_be_i, in, 16: active-high byte enables.
- rsp_valid_o, out, 1: read response valid.
- rsp_ready_i, in, 1: read response ready.
- rsp_rdata_o, out, DATA_WIDTH: read data.
- mem_cen_o, out, 1: SRAM chip enable, active-low.
- mem_wen_o, out, 1: SRAM write enable, active-low (1 = read).
- mem_ben_o, out, 16: SRAM byte enables, active-low.
- mem_a_o, out, ADDR_WIDTH: SRAM address.
- mem_d_o, out, DATA_WIDTH: SRAM write data.
- mem_q_i, in, DATA_WIDTH: SRAM read data, valid the cycle after a read strobe.

Behaviour:
- Reset is asynchronous, active-low. While rst_ni is low and in state S_RST:
  - mem_cen_o=1, mem_wen_o=1, mem_ben_o=16'hFFFF, mem_a_o=0, mem_d_o=0.
  - req_ready_o=0, rsp_valid_o=0, init_done_o=0, rsp_rdata_o=0.
  - FIFO empty, inflight=0, init_cnt=0.
- FSM transitions:
  - S_RST lasts exactly 1 cycle after reset release, then moves to S_INIT if INIT_EN=1, else to S_RUN.
  - S_INIT: each cycle mem_cen_o=0, mem_wen_o=0, mem_ben_o=0, mem_a_o=init_cnt, mem_d_o=0. init_cnt increments each cycle. When init_cnt = all-ones, that write completes and the FSM goes to S_RUN next cycle. The sweep lasts exactly 2**ADDR_WIDTH cycles; req_ready_o=0 throughout.
  - S_RUN is terminal until reset; init_done_o=1 in S_RUN only.
- Credit and ready in S_RUN:
  - req_ready_o = (fifo_count + inflight < RSP_DEPTH). Writes obey the same credit rule; there is no dependency on req_we_i.
- Accept cycle N (req_valid_i & req_ready_o):
  - Combinational: mem_cen_o=0, mem_wen_o=~req_we_i, mem_ben_o=~req_be_i, mem_a_o=req_addr_i, mem_d_o=req_wdata_i.
  - When not accepting, mem_cen_o=1 and the other mem_* outputs follow the request inputs (don't-care).
- Read response timing:
  - An accepted read sets inflight for cycle N+1.
  - In N+1, mem_q_i is pushed into the FIFO.
  - rsp_valid_o rises in N+2, so read-to-response latency is 2 cycles.
  - Writes never produce a response.
- FIFO behaviour:
  - Pop when rsp_valid_o & rsp_ready_i.
  - Push and pop may occur in the same cycle; fifo_count is unchanged.
  - Responses are strictly in request order.
  - rsp_rdata_o holds stable while rsp_valid_o=1 and rsp_ready_i=0.
  - Overflow is impossible by construction; an assertion flags a push while full.
- Memory ordering: the SRAM is single-port and in order. A read accepted the cycle after a write to the same address returns the new data.
- Reset mid-operation:
  - Everything aborts to the reset values, including in-flight reads, FIFO contents and partial init.
  - Init restarts from address 0 after release.

Test Plan:
- Init sweep, ADDR_WIDTH=4 → S_RST 1 cycle; then 16 consecutive cycles with CEN=0, WEN=0, BEN=0, A=0..15, D=0; init_done_o=1 on the following cycle; a read of addr 9 returns 0.
- Write then read back → write addr 3, data 128'h0123..CDEF, be=16'hFFFF; read addr 3 at cycle N → rsp_valid_o at N+2 with the same data; write cycle shows mem_ben_o=16'h0000, mem_wen_o=0.
- Backpressure, rsp_ready_i=0, 5 back-to-back reads → exactly 3 accepted, then req_ready_o=0; raise rsp_ready_i → 3 responses in order, then the remaining 2 accepted and returned in order.
- Throughput, rsp_ready_i=1, 8 consecutive reads of addrs 0..7 → all 8 accepted on 8 consecutive cycles; 8 responses on 8 consecutive cycles starting at N+2.
- Byte enables: write be=16'h0000 → mem_ben_o=16'hFFFF and memory contents unchanged; write be=16'h0001 → mem_ben_o=16'hFFFE.
- Reset mid-init at init_cnt=7 → all outputs return to reset values immediately; after release the sweep restarts at A=0 and runs 16 cycles.
